// File: rtl/id_fetch_buffer.sv
// id_fetch_buffer: instruction buffer between IF and the decoder.
// Each accepted SRAM read reserves one slot. Its response is written one
// cycle later together with the PC of the read. Entries wait here while ID
// is stalled, and a taken branch (flush) drops everything buffered or
// still in flight.
//
// Handshakes (valid/ready): a transfer happens on a rising edge where both
// valid and ready are high and flush is low. ready never depends
// combinationally on valid. req_ready and out_valid come only from
// registered state. Once valid is presented it may be withdrawn only by a
// flush.
module id_fetch_buffer #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    input  logic [PC_W-1:0]   req_pc,
    output logic              req_ready,
    input  logic [INST_W-1:0] inst_sram_rdata,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;
    logic             inflight;
    logic [PC_W-1:0]  pend_pc;
    logic [CNT_W:0]   occupancy;
    logic             accept;
    logic             push;
    logic             pop;

    // Slots in use, including the one held for an outstanding response.
    // Counting that reserved slot means a response can never overflow.
    assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight};
    assign req_ready = occupancy < DEPTH_OCC;

    // Flush takes priority: no accept, push or pop in a flush cycle.
    assign accept = req_valid & req_ready & ~flush;
    assign push   = inflight & ~flush;
    assign pop    = out_valid & out_ready & ~flush;

    // When the buffer is empty, the head is presented as a zero bubble.
    assign out_valid = (count_q != '0);
    assign out_pc    = out_valid ? pc_mem[head_ptr]   : '0;
    assign out_inst  = out_valid ? inst_mem[head_ptr] : '0;
    assign count     = count_q;

    // Occupancy update. A push and a pop together leave it unchanged.
    always_comb begin
        count_next = count_q;
        case ({push, pop})
            2'b10:   count_next = count_q + CNT_W'(1);
            2'b01:   count_next = count_q - CNT_W'(1);
            default: count_next = count_q;
        endcase
    end

    // Pointer, occupancy and in-flight tracking. Flush clears it all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count_q  <= '0;
            inflight <= 1'b0;
            pend_pc  <= '0;
        end else begin
            inflight <= accept;
            if (accept) begin
                pend_pc <= req_pc;
            end
            if (flush) begin
                head_ptr <= '0;
                tail_ptr <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    tail_ptr <= tail_ptr + PTR_W'(1);
                end
                if (pop) begin
                    head_ptr <= head_ptr + PTR_W'(1);
                end
                count_q <= count_next;
            end
        end
    end

    // Entry storage. It is not reset because validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_ptr]   <= pend_pc;
            inst_mem[tail_ptr] <= inst_sram_rdata;
        end
    end

endmodule
